// File: rtl/operadores_pkg.sv
// operadores_pkg: shared state encoding, default widths and counter limits for the majority unpacker
package operadores_pkg;
  localparam logic [1:0] ST_R0  = 2'd0;
  localparam logic [1:0] ST_R1  = 2'd1;
  localparam logic [1:0] ST_R2  = 2'd2;
  localparam logic [1:0] ST_OUT = 2'd3;
  localparam int W_DEF  = 3;
  localparam int SH_DEF = 2;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
endpackage

// File: rtl/desempacotador_maioria_if.sv
// desempacotador_maioria_if: link-side beat stream and consumer-side decoded word bundle
interface desempacotador_maioria_if #(parameter int W = operadores_pkg::W_DEF);
  logic                            in_valid;
  logic                            in_ready;
  logic [2*W-1:0]                  in_data;
  logic                            in_first;
  logic                            in_shl;
  logic                            out_valid;
  logic                            out_ready;
  logic [2*W-1:0]                  out_word;
  logic [W-1:0]                    out_a;
  logic [W-1:0]                    out_b;
  logic                            out_corr;
  logic                            sync_err;
  logic [operadores_pkg::CNT_W-1:0] corr_cnt;
  modport master (
    output in_valid, in_data, in_first, in_shl, out_ready,
    input  in_ready, out_valid, out_word, out_a, out_b, out_corr, sync_err, corr_cnt
  );
  modport slave (
    input  in_valid, in_data, in_first, in_shl, out_ready,
    output in_ready, out_valid, out_word, out_a, out_b, out_corr, sync_err, corr_cnt
  );
endinterface

// File: rtl/votador_maioria.sv
// votador_maioria: bitwise 3-input majority vote with any-bit disagreement flag
module votador_maioria #(parameter int N = 6) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] v,
  output logic         dis
);
  assign v   = (a & b) | (a & c) | (b & c);
  assign dis = |((a ^ b) | (a ^ c));
endmodule

// File: rtl/desempacotador_maioria.sv
// desempacotador_maioria: collects 3 replicas, votes them, undoes optional shift and counts corrections
module desempacotador_maioria
  import operadores_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SH = SH_DEF
) (
  input logic clk,
  input logic reset,
  desempacotador_maioria_if.slave bus
);
  localparam int N = 2 * W;
  logic [1:0]       state_q, state_d;
  logic [N-1:0]     r0_q, r0_d, r1_q, r1_d, word_q, word_d, vote;
  logic             shl_q, shl_d, corr_q, corr_d, sync_q, sync_d, dis, acc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // the third replica is voted straight off the bus in the cycle it is accepted
  votador_maioria #(.N(N)) u_votador (
    .a  (r0_q),
    .b  (r1_q),
    .c  (bus.in_data),
    .v  (vote),
    .dis(dis)
  );
  assign bus.in_ready  = state_q != ST_OUT;
  assign bus.out_valid = state_q == ST_OUT;
  assign bus.out_word  = word_q;
  assign bus.out_a     = word_q[N-1:W];
  assign bus.out_b     = word_q[W-1:0];
  assign bus.out_corr  = corr_q;
  assign bus.sync_err  = sync_q;
  assign bus.corr_cnt  = cnt_q;
  assign acc           = bus.in_valid & bus.in_ready;
  // frame sequencing: a first-marked beat always (re)starts a frame, a stray beat in R0 is dropped
  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    shl_d   = shl_q;
    word_d  = word_q;
    corr_d  = corr_q;
    cnt_d   = cnt_q;
    sync_d  = 1'b0;
    if (acc) begin
      if (bus.in_first) begin
        r0_d    = bus.in_data;
        shl_d   = bus.in_shl;
        state_d = ST_R1;
        sync_d  = state_q != ST_R0;
      end else if (state_q == ST_R0) begin
        sync_d = 1'b1;
      end else if (state_q == ST_R1) begin
        r1_d    = bus.in_data;
        state_d = ST_R2;
      end else begin
        word_d  = shl_q ? vote >> SH : vote;
        corr_d  = dis;
        cnt_d   = (dis && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        state_d = ST_OUT;
      end
    end else if (state_q == ST_OUT && bus.out_ready) begin
      state_d = ST_R0;
    end
  end
  // state and output registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_R0;
      r0_q    <= '0;
      r1_q    <= '0;
      shl_q   <= 1'b0;
      word_q  <= '0;
      corr_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      shl_q   <= shl_d;
      word_q  <= word_d;
      corr_q  <= corr_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_desempacotador_maioria.sv
// tb_desempacotador_maioria: directed checks of voting, un-shift, framing, backpressure, saturation and reset
module tb_desempacotador_maioria;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  desempacotador_maioria_if #(.W(3)) bus ();
  desempacotador_maioria #(.W(3), .SH(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [5:0] d, input logic f, input logic s);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_first = f;
    bus.in_shl   = s;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_shl   = 1'b0;
  endtask
  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_first  = 1'b0;
    bus.in_shl    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_word", bus.out_word, 0);
    chk("rst_corr", bus.out_corr, 0);
    chk("rst_sync", bus.sync_err, 0);
    chk("rst_cnt", bus.corr_cnt, 0);
    chk("rst_ready", bus.in_ready, 1);
    reset = 1'b0;
    send(6'b101011, 1, 0);
    send(6'b101011, 0, 0);
    chk("t1_not_yet", bus.out_valid, 0);
    send(6'b101011, 0, 0);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_word", bus.out_word, 6'b101011);
    chk("t1_a", bus.out_a, 3'b101);
    chk("t1_b", bus.out_b, 3'b011);
    chk("t1_corr", bus.out_corr, 0);
    chk("t1_cnt", bus.corr_cnt, 0);
    chk("t1_ready", bus.in_ready, 0);
    consume();
    chk("t1_drop_valid", bus.out_valid, 0);
    chk("t1_word_kept", bus.out_word, 6'b101011);
    send(6'b101011, 1, 0);
    send(6'b111011, 0, 0);
    send(6'b101011, 0, 0);
    chk("t2_word", bus.out_word, 6'b101011);
    chk("t2_corr", bus.out_corr, 1);
    chk("t2_cnt", bus.corr_cnt, 1);
    consume();
    send(6'b101100, 1, 1);
    send(6'b101100, 0, 0);
    send(6'b101100, 0, 0);
    chk("t3_word", bus.out_word, 6'b001011);
    chk("t3_a", bus.out_a, 3'b001);
    chk("t3_b", bus.out_b, 3'b011);
    chk("t3_corr", bus.out_corr, 0);
    consume();
    send(6'b010101, 0, 0);
    chk("t4_stray_sync", bus.sync_err, 1);
    chk("t4_stray_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    chk("t4_sync_pulse", bus.sync_err, 0);
    send(6'b110001, 1, 0);
    chk("t4_first_nosync", bus.sync_err, 0);
    send(6'b011110, 1, 0);
    chk("t4_restart_sync", bus.sync_err, 1);
    send(6'b011110, 0, 0);
    chk("t4_after_sync", bus.sync_err, 0);
    chk("t4_mid_valid", bus.out_valid, 0);
    send(6'b011110, 0, 0);
    chk("t4_valid", bus.out_valid, 1);
    chk("t4_word", bus.out_word, 6'b011110);
    chk("t4_corr", bus.out_corr, 0);
    chk("t4_cnt", bus.corr_cnt, 1);
    consume();
    send(6'b110011, 1, 0);
    send(6'b110011, 0, 0);
    send(6'b010011, 0, 0);
    chk("t5_cnt", bus.corr_cnt, 2);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_first = 1'b1;
      bus.in_data  = 6'b000000;
      @(posedge clk);
      #1;
      chk("t5_hold_valid", bus.out_valid, 1);
      chk("t5_hold_word", bus.out_word, 6'b110011);
      chk("t5_hold_ready", bus.in_ready, 0);
      chk("t5_hold_sync", bus.sync_err, 0);
    end
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    consume();
    chk("t5_release_valid", bus.out_valid, 0);
    chk("t5_release_ready", bus.in_ready, 1);
    for (int i = 0; i < 253; i++) begin
      send(6'b000000, 1, 0);
      send(6'b000001, 0, 0);
      send(6'b000000, 0, 0);
      consume();
    end
    chk("t5_cnt_255", bus.corr_cnt, 255);
    for (int i = 0; i < 5; i++) begin
      send(6'b000000, 1, 0);
      send(6'b100000, 0, 0);
      send(6'b000000, 0, 0);
      consume();
    end
    chk("t5_cnt_sat", bus.corr_cnt, 255);
    send(6'b111111, 1, 0);
    send(6'b111111, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_word", bus.out_word, 0);
    chk("t6_corr", bus.out_corr, 0);
    chk("t6_cnt", bus.corr_cnt, 0);
    chk("t6_sync", bus.sync_err, 0);
    chk("t6_ready", bus.in_ready, 1);
    reset = 1'b0;
    send(6'b000000, 0, 0);
    chk("t6_state_r0", bus.sync_err, 1);
    send(6'b100001, 1, 0);
    send(6'b100001, 0, 0);
    send(6'b100001, 0, 0);
    chk("t6_word_new", bus.out_word, 6'b100001);
    chk("t6_a_new", bus.out_a, 3'b100);
    chk("t6_b_new", bus.out_b, 3'b001);
    chk("t6_cnt_new", bus.corr_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
